signed_seq_divider: RTL and testbench



---
 rtl/signed_seq_divider.sv | 143 ++++++++++++++
 tb/tb_signed_seq_divider.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/signed_seq_divider.sv
// Iterative signed divider: 2*WIDTH-bit dividend / WIDTH-bit divisor, restoring
// shift-subtract on magnitudes, one quotient bit per enabled clock, truncating toward zero.
module signed_seq_divider #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               en,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);
  localparam int DW = 2 * WIDTH;
  localparam int CW = $clog2(DW);

  typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    num_q, num_d;      // dividend magnitude shifting out, quotient shifting in
  logic [WIDTH-1:0] den_q, den_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             done_q, done_d, dbz_q, dbz_d, ovf_q, ovf_d;
  logic [WIDTH-1:0] quo_q, quo_d, remo_q, remo_d;

  logic [DW-1:0]    dvd_mag, qs;
  logic [WIDTH-1:0] dvs_mag;
  logic [WIDTH:0]   rem_shift, diff;
  logic             ge, ovf_pos, ovf_neg;

  assign dvd_mag   = dividend[DW-1] ? -dividend : dividend;
  assign dvs_mag   = divisor[WIDTH-1] ? -divisor : divisor;
  assign rem_shift = {rem_q, num_q[DW-1]};
  assign ge        = rem_shift >= {1'b0, den_q};
  assign diff      = rem_shift - {1'b0, den_q};
  assign qs        = qneg_q ? -num_q : num_q;
  // Range test on the unsigned magnitude so that +2^(DW-1) is not mistaken for negative.
  assign ovf_pos   = |num_q[DW-1:WIDTH-1];
  assign ovf_neg   = (|num_q[DW-1:WIDTH]) | (num_q[WIDTH-1] & (|num_q[WIDTH-2:0]));

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      num_q   <= '0;
      den_q   <= '0;
      rem_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
      ovf_q   <= 1'b0;
      quo_q   <= '0;
      remo_q  <= '0;
    end else if (en) begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      num_q   <= num_d;
      den_q   <= den_d;
      rem_q   <= rem_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
      ovf_q   <= ovf_d;
      quo_q   <= quo_d;
      remo_q  <= remo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start && (divisor != '0)) state_d = CALC;
      CALC:    if (cnt_q == CW'(DW - 1)) state_d = FIX;
      FIX:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cnt_d  = cnt_q;
    num_d  = num_q;
    den_d  = den_q;
    rem_d  = rem_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    done_d = 1'b0;
    dbz_d  = dbz_q;
    ovf_d  = ovf_q;
    quo_d  = quo_q;
    remo_d = remo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            quo_d  = '1;
            remo_d = dividend[WIDTH-1:0];
            dbz_d  = 1'b1;
            ovf_d  = 1'b0;
            done_d = 1'b1;
          end else begin
            num_d  = dvd_mag;
            den_d  = dvs_mag;
            rem_d  = '0;
            cnt_d  = '0;
            qneg_d = dividend[DW-1] ^ divisor[WIDTH-1];
            rneg_d = dividend[DW-1];
          end
        end
      end
      CALC: begin
        num_d = {num_q[DW-2:0], ge};
        rem_d = ge ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
        cnt_d = cnt_q + 1'b1;
      end
      FIX: begin
        quo_d  = qs[WIDTH-1:0];
        remo_d = rneg_q ? -rem_q : rem_q;
        ovf_d  = qneg_q ? ovf_neg : ovf_pos;
        dbz_d  = 1'b0;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy        = (state_q != IDLE);
    done        = done_q;
    quotient    = quo_q;
    remainder   = remo_q;
    div_by_zero = dbz_q;
    overflow    = ovf_q;
  end
endmodule

// File: tb/tb_signed_seq_divider.sv
// Directed-vector bench: stimulus pushes expected results, a negedge monitor pops them
// on every enabled done pulse; latency, handshake, enable and reset are checked inline.
module tb_signed_seq_divider;
  logic        clk = 1'b0;
  logic        reset, en, start;
  logic [63:0] dividend;
  logic [31:0] divisor;
  logic        busy, done, div_by_zero, overflow;
  logic [31:0] quotient, remainder;

  typedef struct {
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  bit   en_last = 1'b0;

  signed_seq_divider #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .en(en), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(posedge clk) en_last = en;

  // Monitor: one pop per done pulse seen after an enabled edge.
  always @(negedge clk) begin
    if (done === 1'b1 && en_last && !reset) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done), 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("quotient", 64'(quotient), 64'(e.q));
        check("remainder", 64'(remainder), 64'(e.r));
        check("div_by_zero", 64'(div_by_zero), 64'(e.dbz));
        check("overflow", 64'(overflow), 64'(e.ovf));
      end
    end
  end

  // Start lands on the next rising edge (edge N); returns #1 after edge N.
  task automatic issue(input longint a, input int b, input int eq, input int er,
                       input bit edbz, input bit eovf, input bit push);
    exp_t e;
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    if (push) begin
      e.q = eq; e.r = er; e.dbz = edbz; e.ovf = eovf;
      sb.push_back(e);
    end
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Counts edges after N until done is seen; busy must stay high until then.
  task automatic wait_done(input string name, input int n0, input int exp_lat);
    int n = n0;
    bit bsy_ok = 1'b1;
    while (!done && n < 300) begin
      if (!busy) bsy_ok = 1'b0;
      @(posedge clk);
      #1;
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(exp_lat));
    check({name, "_busy_during"}, 64'(bsy_ok), 64'd1);
    check({name, "_busy_at_done"}, 64'(busy), 64'd0);
  endtask

  task automatic op(input string name, input longint a, input int b, input int eq,
                    input int er, input bit edbz, input bit eovf, input int lat);
    issue(a, b, eq, er, edbz, eovf, 1'b1);
    wait_done(name, 0, lat);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog_timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1; en = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_q_r", {quotient, remainder}, 64'd0);
    check("rst_flags", 64'({div_by_zero, overflow}), 64'd0);
    reset = 1'b0;

    op("max_pos", 64'sh7FFFFFFF, 1, 32'h7FFFFFFF, 0, 0, 0, 65);
    op("m4_m2", -4, -2, 2, 0, 0, 0, 65);
    op("m4_2", -4, 2, -2, 0, 0, 0, 65);
    op("7_m2", 7, -2, -3, 1, 0, 0, 65);
    op("m7_2", -7, 2, -3, -1, 0, 0, 65);
    op("3_m1", 3, -1, -3, 0, 0, 0, 65);
    op("rt_min", 64'h4000000000000000, 32'h80000000, 32'h80000000, 0, 0, 0, 65);
    op("ovf_big", 64'h4000000000000000, 1, 0, 0, 0, 1, 65);
    op("ovf_min_m1", 64'h8000000000000000, -1, 0, 0, 0, 1, 65);
    op("dbz", 100, 0, 32'hFFFFFFFF, 100, 1, 0, 0);
    op("after_dbz", 10, 3, 3, 1, 0, 0, 65);

    // start during busy is ignored
    issue(1000, 7, 142, 6, 0, 0, 1);
    repeat (9) begin @(posedge clk); #1; end
    @(negedge clk); dividend = 64'd5; divisor = 32'd5; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    wait_done("ign_start", 10, 65);

    // en low for 10 edges mid-CALC
    issue(-1000, 7, -142, -6, 0, 0, 1);
    repeat (19) begin @(posedge clk); #1; end
    en = 1'b0;
    repeat (10) begin @(posedge clk); #1; end
    en = 1'b1;
    wait_done("en_stall", 29, 75);
    en = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    check("done_held_en0", 64'(done), 64'd1);
    check("q_held_en0", 64'(quotient), 64'(32'hFFFFFF72));
    en = 1'b1;
    @(posedge clk); #1;
    check("done_cleared", 64'(done), 64'd0);

    // reset mid-CALC discards the operation
    issue(123456, 3, 0, 0, 0, 0, 0);
    repeat (19) begin @(posedge clk); #1; end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_q_r", {quotient, remainder}, 64'd0);
    check("midrst_flags", 64'({done, div_by_zero, overflow}), 64'd0);
    begin
      bit seen = 1'b0;
      repeat (70) begin @(posedge clk); #1; if (done) seen = 1'b1; end
      check("midrst_no_done", 64'(seen), 64'd0);
    end

    op("post_rst", 12345, -7, -1763, 4, 0, 0, 65);

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
